// File: rtl/dram_req_arbiter.sv
// Round-robin arbiter sharing one DRAM request/write-data/read-data FIFO set between two clients.
// Read data is steered back to the issuing client through an in-order tag queue.
module dram_req_arbiter #(
    parameter int unsigned PAGE_LEN      = 4,
    parameter int unsigned LOG_ADDR_SIZE = 4,
    parameter int unsigned LOG_REQ_SIZE  = 5,
    parameter int unsigned TAG_DEPTH     = 4
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         c0_rq_valid,
    input  logic [LOG_REQ_SIZE-1:0]      c0_rq_data,
    input  logic [PAGE_LEN-1:0]          c0_wd_data,
    output logic                         c0_rq_ready,
    output logic                         c0_rd_valid,
    output logic [PAGE_LEN-1:0]          c0_rd_data,
    input  logic                         c0_rd_ready,

    input  logic                         c1_rq_valid,
    input  logic [LOG_REQ_SIZE-1:0]      c1_rq_data,
    input  logic [PAGE_LEN-1:0]          c1_wd_data,
    output logic                         c1_rq_ready,
    output logic                         c1_rd_valid,
    output logic [PAGE_LEN-1:0]          c1_rd_data,
    input  logic                         c1_rd_ready,

    output logic                         frq_write_en,
    output logic [LOG_REQ_SIZE-1:0]      frq_write_data,
    input  logic                         frq_full,

    output logic                         fout_write_en,
    output logic [PAGE_LEN-1:0]          fout_write_data,
    input  logic                         fout_full,

    output logic                         fin_read_en,
    input  logic [PAGE_LEN-1:0]          fin_read_data,
    input  logic                         fin_empty,

    output logic [$clog2(TAG_DEPTH):0]   outstanding,
    output logic                         error
);

    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic               rr_last;
    logic               tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic tq_full;
    logic tq_empty;
    logic c0_is_wr;
    logic c1_is_wr;
    logic elig0;
    logic elig1;
    logic gnt0;
    logic gnt1;
    logic rd_push;
    logic head_tag;
    logic head_free;
    logic pop;

    // Eligibility, round-robin grant and return-path pop decision
    always_comb begin
        tq_full   = (count == CNT_W'(TAG_DEPTH));
        tq_empty  = (count == '0);
        c0_is_wr  = c0_rq_data[LOG_ADDR_SIZE];
        c1_is_wr  = c1_rq_data[LOG_ADDR_SIZE];
        elig0     = c0_rq_valid & !frq_full & (c0_is_wr ? !fout_full : !tq_full);
        elig1     = c1_rq_valid & !frq_full & (c1_is_wr ? !fout_full : !tq_full);
        // rr_last names the client served last; the other one wins a tie
        gnt0      = elig0 & (!elig1 | rr_last);
        gnt1      = elig1 & (!elig0 | !rr_last);
        rd_push   = (gnt0 & !c0_is_wr) | (gnt1 & !c1_is_wr);
        head_tag  = tag_mem[rd_ptr];
        head_free = head_tag ? (!c1_rd_valid | c1_rd_ready) : (!c0_rd_valid | c0_rd_ready);
        pop       = !fin_empty & !tq_empty & head_free;
    end

    // Same-cycle FIFO push / client handshake outputs, forced quiet during reset
    always_comb begin
        c0_rq_ready     = gnt0 & !rst;
        c1_rq_ready     = gnt1 & !rst;
        frq_write_en    = (gnt0 | gnt1) & !rst;
        frq_write_data  = '0;
        fout_write_en   = ((gnt0 & c0_is_wr) | (gnt1 & c1_is_wr)) & !rst;
        fout_write_data = '0;
        fin_read_en     = pop & !rst;
        if (c0_rq_ready) begin
            frq_write_data = c0_rq_data;
        end else if (c1_rq_ready) begin
            frq_write_data = c1_rq_data;
        end
        if (fout_write_en) begin
            fout_write_data = gnt0 ? c0_wd_data : c1_wd_data;
        end
    end

    assign outstanding = count;

    // Arbitration history, tag queue pointers, holding registers and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last     <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            c0_rd_valid <= 1'b0;
            c0_rd_data  <= '0;
            c1_rd_valid <= 1'b0;
            c1_rd_data  <= '0;
            error       <= 1'b0;
        end else begin
            if (gnt0) begin
                rr_last <= 1'b0;
            end else if (gnt1) begin
                rr_last <= 1'b1;
            end

            if (rd_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(rd_push) - CNT_W'(pop);

            if (pop && !head_tag) begin
                c0_rd_data  <= fin_read_data;
                c0_rd_valid <= 1'b1;
            end else if (c0_rd_ready) begin
                c0_rd_valid <= 1'b0;
            end

            if (pop && head_tag) begin
                c1_rd_data  <= fin_read_data;
                c1_rd_valid <= 1'b1;
            end else if (c1_rd_ready) begin
                c1_rd_valid <= 1'b0;
            end

            // Read data arriving with nothing outstanding is left in the FIFO and flagged
            if (!fin_empty && tq_empty) begin
                error <= 1'b1;
            end
        end
    end

    // Tag storage needs no reset: entries are only read behind the write pointer
    always_ff @(posedge clk) begin
        if (rd_push) begin
            tag_mem[wr_ptr] <= gnt1;
        end
    end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed bench for dram_req_arbiter: FIFO push and read-return scoreboards plus immediate-assertion checks.
module tb_dram_req_arbiter;

    localparam int unsigned PL = 4;
    localparam int unsigned RW = 5;

    typedef struct packed {
        logic [RW-1:0] req;
        logic          wen;
        logic [PL-1:0] wd;
    } rq_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          c0_rq_valid, c1_rq_valid;
    logic [RW-1:0] c0_rq_data, c1_rq_data;
    logic [PL-1:0] c0_wd_data, c1_wd_data;
    logic          c0_rq_ready, c1_rq_ready;
    logic          c0_rd_valid, c1_rd_valid;
    logic [PL-1:0] c0_rd_data, c1_rd_data;
    logic          c0_rd_ready, c1_rd_ready;
    logic          frq_write_en;
    logic [RW-1:0] frq_write_data;
    logic          frq_full;
    logic          fout_write_en;
    logic [PL-1:0] fout_write_data;
    logic          fout_full;
    logic          fin_read_en;
    logic [PL-1:0] fin_read_data;
    logic          fin_empty;
    logic [2:0]    outstanding;
    logic          error;

    int checks = 0;
    int errors = 0;

    rq_t           exp_rq[$];
    logic [PL-1:0] exp_rd0[$];
    logic [PL-1:0] exp_rd1[$];
    logic [PL-1:0] rdq[$];

    always #5 clk = ~clk;

    dram_req_arbiter dut (
        .clk(clk), .rst(rst),
        .c0_rq_valid(c0_rq_valid), .c0_rq_data(c0_rq_data), .c0_wd_data(c0_wd_data),
        .c0_rq_ready(c0_rq_ready), .c0_rd_valid(c0_rd_valid), .c0_rd_data(c0_rd_data),
        .c0_rd_ready(c0_rd_ready),
        .c1_rq_valid(c1_rq_valid), .c1_rq_data(c1_rq_data), .c1_wd_data(c1_wd_data),
        .c1_rq_ready(c1_rq_ready), .c1_rd_valid(c1_rd_valid), .c1_rd_data(c1_rd_data),
        .c1_rd_ready(c1_rd_ready),
        .frq_write_en(frq_write_en), .frq_write_data(frq_write_data), .frq_full(frq_full),
        .fout_write_en(fout_write_en), .fout_write_data(fout_write_data), .fout_full(fout_full),
        .fin_read_en(fin_read_en), .fin_read_data(fin_read_data), .fin_empty(fin_empty),
        .outstanding(outstanding), .error(error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Read-data FIFO model: first-word-fall-through head
    task automatic upd_fin();
        fin_empty     = (rdq.size() == 0);
        fin_read_data = (rdq.size() != 0) ? rdq[0] : '0;
    endtask

    task automatic ret(input logic [PL-1:0] d, input bit to_c1);
        rdq.push_back(d);
        if (to_c1) exp_rd1.push_back(d);
        else       exp_rd0.push_back(d);
        upd_fin();
    endtask

    task automatic exp_push(input logic [RW-1:0] req, input logic wen, input logic [PL-1:0] wd);
        rq_t e;
        e.req = req;
        e.wen = wen;
        e.wd  = wd;
        exp_rq.push_back(e);
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Scoreboard compare at the sample point, then advance one clock edge
    task automatic adv();
        bit   pop_now;
        rq_t  e;
        chk("fout_en_without_frq", 32'(fout_write_en & !frq_write_en), 32'd0);
        if (frq_write_en) begin
            if (exp_rq.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rq_unexpected: observed=%0h expected=none", frq_write_data);
            end else begin
                e = exp_rq.pop_front();
                chk("frq_data", 32'(frq_write_data), 32'(e.req));
                chk("fout_en", 32'(fout_write_en), 32'(e.wen));
                chk("fout_data", 32'(fout_write_data), 32'(e.wd));
            end
        end
        if (c0_rd_valid && c0_rd_ready) begin
            if (exp_rd0.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rd0_unexpected: observed=%0h expected=none", c0_rd_data);
            end else begin
                chk("rd0_data", 32'(c0_rd_data), 32'(exp_rd0.pop_front()));
            end
        end
        if (c1_rd_valid && c1_rd_ready) begin
            if (exp_rd1.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL rd1_unexpected: observed=%0h expected=none", c1_rd_data);
            end else begin
                chk("rd1_data", 32'(c1_rd_data), 32'(exp_rd1.pop_front()));
            end
        end
        pop_now = fin_read_en;
        @(posedge clk);
        #1;
        if (pop_now && rdq.size() != 0) void'(rdq.pop_front());
        upd_fin();
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            settle();
            done = (outstanding == 0) && !c0_rd_valid && !c1_rd_valid;
            adv();
        end
        chk("drain_outstanding", 32'(outstanding), 32'd0);
        chk("drain_rd0_left", 32'(exp_rd0.size()), 32'd0);
        chk("drain_rd1_left", 32'(exp_rd1.size()), 32'd0);
    endtask

    task automatic idle_clients();
        c0_rq_valid = 1'b0;
        c1_rq_valid = 1'b0;
        c0_rq_data  = '0;
        c1_rq_data  = '0;
        c0_wd_data  = '0;
        c1_wd_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        idle_clients();
        c0_rd_ready = 1'b1;
        c1_rd_ready = 1'b1;
        frq_full    = 1'b0;
        fout_full   = 1'b0;
        upd_fin();

        // Reset: outputs quiet even with a client requesting
        c0_rq_valid = 1'b1;
        c0_rq_data  = 5'b0_0011;
        settle();
        chk("rst_c0_ready", 32'(c0_rq_ready), 32'd0);
        chk("rst_frq_en", 32'(frq_write_en), 32'd0);
        chk("rst_frq_data", 32'(frq_write_data), 32'd0);
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_rd_valid", 32'({c0_rd_valid, c1_rd_valid}), 32'd0);
        adv();
        idle_clients();
        rst = 1'b0;
        cyc();

        // Both clients reading continuously: 0,1,0,1 then stall on full tag queue
        c0_rq_valid = 1'b1;
        c0_rq_data  = 5'b0_0001;
        c1_rq_valid = 1'b1;
        c1_rq_data  = 5'b0_1001;
        for (int k = 0; k < 6; k++) begin
            if (k < 4) exp_push((k % 2 == 0) ? 5'b0_0001 : 5'b0_1001, 1'b0, '0);
            settle();
            chk($sformatf("rr_c0_ready_%0d", k), 32'(c0_rq_ready), 32'((k < 4) && (k % 2 == 0)));
            chk($sformatf("rr_c1_ready_%0d", k), 32'(c1_rq_ready), 32'((k < 4) && (k % 2 == 1)));
            chk($sformatf("rr_outstanding_%0d", k), 32'(outstanding), 32'((k < 4) ? k : 4));
            adv();
        end
        // One return frees a slot; grant uses the pre-pop count, so c0 waits a cycle
        c1_rq_valid = 1'b0;
        ret(4'h3, 1'b0);
        settle();
        chk("full_pop_en", 32'(fin_read_en), 32'd1);
        chk("full_no_grant", 32'(c0_rq_ready), 32'd0);
        adv();
        exp_push(5'b0_0001, 1'b0, '0);
        settle();
        chk("after_pop_grant", 32'(c0_rq_ready), 32'd1);
        chk("after_pop_outstanding", 32'(outstanding), 32'd3);
        adv();
        idle_clients();
        ret(4'h4, 1'b1);
        ret(4'h5, 1'b0);
        ret(4'h6, 1'b1);
        ret(4'h7, 1'b0);
        drain(30);

        // In-order routing: c0 addr 2, c1 addr 5, c0 addr 7
        c0_rq_valid = 1'b1; c0_rq_data = 5'b0_0010; exp_push(5'b0_0010, 1'b0, '0);
        settle(); chk("seq_c0_a2", 32'(c0_rq_ready), 32'd1); adv();
        idle_clients();
        c1_rq_valid = 1'b1; c1_rq_data = 5'b0_0101; exp_push(5'b0_0101, 1'b0, '0);
        settle(); chk("seq_c1_a5", 32'(c1_rq_ready), 32'd1); adv();
        idle_clients();
        c0_rq_valid = 1'b1; c0_rq_data = 5'b0_0111; exp_push(5'b0_0111, 1'b0, '0);
        settle(); chk("seq_c0_a7", 32'(c0_rq_ready), 32'd1); adv();
        idle_clients();
        settle(); chk("seq_outstanding", 32'(outstanding), 32'd3); adv();
        ret(4'h2, 1'b0);
        ret(4'h5, 1'b1);
        ret(4'h7, 1'b0);
        drain(30);

        // Holding register backpressure: second word stays in the FIFO
        c0_rd_ready = 1'b0;
        c0_rq_valid = 1'b1; c0_rq_data = 5'b0_0011; exp_push(5'b0_0011, 1'b0, '0); cyc();
        c0_rq_data = 5'b0_0100; exp_push(5'b0_0100, 1'b0, '0); cyc();
        idle_clients();
        ret(4'h8, 1'b0);
        ret(4'h9, 1'b0);
        settle(); chk("hold_first_pop", 32'(fin_read_en), 32'd1); adv();
        for (int k = 0; k < 2; k++) begin
            settle();
            chk($sformatf("hold_valid_%0d", k), 32'(c0_rd_valid), 32'd1);
            chk($sformatf("hold_data_%0d", k), 32'(c0_rd_data), 32'h8);
            chk($sformatf("hold_no_pop_%0d", k), 32'(fin_read_en), 32'd0);
            adv();
        end
        c0_rd_ready = 1'b1;
        settle(); chk("drain_pop2", 32'(fin_read_en), 32'd1); adv();
        settle();
        chk("drain_data2", 32'(c0_rd_data), 32'h9);
        chk("drain_no_pop", 32'(fin_read_en), 32'd0);
        chk("drain_outst", 32'(outstanding), 32'd0);
        adv();
        settle(); chk("drain_valid_clr", 32'(c0_rd_valid), 32'd0); adv();

        // Request FIFO full blocks everyone; write-data FIFO full blocks only writes
        frq_full    = 1'b1;
        c0_rq_valid = 1'b1; c0_rq_data = 5'b1_0001; c0_wd_data = 4'hE;
        c1_rq_valid = 1'b1; c1_rq_data = 5'b0_0110;
        settle();
        chk("frqfull_ready", 32'({c0_rq_ready, c1_rq_ready}), 32'd0);
        chk("frqfull_push", 32'({frq_write_en, fout_write_en}), 32'd0);
        chk("frqfull_data", 32'(frq_write_data), 32'd0);
        adv();
        frq_full  = 1'b0;
        fout_full = 1'b1;
        exp_push(5'b0_0110, 1'b0, '0);
        settle();
        chk("foutfull_c1", 32'(c1_rq_ready), 32'd1);
        chk("foutfull_c0", 32'(c0_rq_ready), 32'd0);
        adv();
        idle_clients();
        fout_full = 1'b0;
        ret(4'hC, 1'b1);
        drain(20);

        // Client 0 writes addr 0..3 with data A..D
        for (int a = 0; a < 4; a++) begin
            c0_rq_valid = 1'b1;
            c0_rq_data  = {1'b1, 4'(a)};
            c0_wd_data  = 4'(4'hA + a);
            exp_push({1'b1, 4'(a)}, 1'b1, 4'(4'hA + a));
            settle();
            chk($sformatf("wr_ready_%0d", a), 32'(c0_rq_ready), 32'd1);
            chk($sformatf("wr_fout_en_%0d", a), 32'(fout_write_en), 32'd1);
            chk($sformatf("wr_outst_%0d", a), 32'(outstanding), 32'd0);
            adv();
        end
        idle_clients();
        settle();
        chk("idle_frq_en", 32'(frq_write_en), 32'd0);
        chk("idle_fout_data", 32'(fout_write_data), 32'd0);
        adv();

        // Unsolicited read data: sticky error, data left in the FIFO
        rdq.push_back(4'hF);
        upd_fin();
        settle();
        chk("err_pre", 32'(error), 32'd0);
        chk("err_no_pop", 32'(fin_read_en), 32'd0);
        adv();
        settle();
        chk("err_set", 32'(error), 32'd1);
        chk("err_no_pop2", 32'(fin_read_en), 32'd0);
        adv();
        rdq.delete();
        upd_fin();
        settle(); chk("err_sticky", 32'(error), 32'd1); adv();

        // Reset mid-burst with a word held for client 1
        c0_rd_ready = 1'b0;
        c1_rd_ready = 1'b0;
        c0_rq_valid = 1'b1; c0_rq_data = 5'b0_0001;
        c1_rq_valid = 1'b1; c1_rq_data = 5'b0_0010;
        exp_push(5'b0_0010, 1'b0, '0);
        cyc();
        exp_push(5'b0_0001, 1'b0, '0);
        ret(4'h1, 1'b1);
        cyc();
        exp_push(5'b0_0010, 1'b0, '0);
        settle();
        chk("burst_c1_held", 32'(c1_rd_valid), 32'd1);
        chk("burst_outst", 32'(outstanding), 32'd1);
        adv();
        rst = 1'b1;
        rdq.delete();
        exp_rd0.delete();
        exp_rd1.delete();
        upd_fin();
        #1;
        chk("mid_rst_ready", 32'({c0_rq_ready, c1_rq_ready}), 32'd0);
        chk("mid_rst_push", 32'({frq_write_en, fout_write_en, fin_read_en}), 32'd0);
        chk("mid_rst_outst", 32'(outstanding), 32'd0);
        chk("mid_rst_error", 32'(error), 32'd0);
        chk("mid_rst_rd_valid", 32'({c0_rd_valid, c1_rd_valid}), 32'd0);
        cyc();
        rst = 1'b0;
        c0_rd_ready = 1'b1;
        c1_rd_ready = 1'b1;
        exp_push(5'b0_0001, 1'b0, '0);
        settle();
        chk("post_rst_c0_first", 32'(c0_rq_ready), 32'd1);
        chk("post_rst_c1_wait", 32'(c1_rq_ready), 32'd0);
        adv();
        idle_clients();
        ret(4'h6, 1'b0);
        drain(20);
        chk("rq_sb_left", 32'(exp_rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
